// File: rtl/dithering_pkg.sv
// Shared types and constants for the dithering_rgb pixel quantiser.
//   mode_e    : run-time quantisation mode (anything not ED/ORD behaves as truncate)
//   BAYER4    : 4x4 ordered-dither threshold matrix, values 0..15
//   bayer_idx : matrix lookup by (row, col)
package dithering_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC = 2'b00,
    MODE_ED    = 2'b01,
    MODE_ORD   = 2'b10
  } mode_e;

  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  function automatic logic [3:0] bayer_idx(input logic [1:0] row, input logic [1:0] col);
    return BAYER4[row][col];
  endfunction

endpackage

// File: rtl/dither_channel.sv
// One colour channel of the quantiser: truncate, 1-D error diffusion or ordered dither,
// selected per pixel by mode_i. Holds this channel's diffusion error and output register.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   valid_i       : pixel qualifier; state and output update only when set
//   clr_err_i     : qualified frame start; error treated as 0 for this pixel
//   line_end_i    : qualified line end; error cleared after this pixel
//   mode_i        : active mode for this pixel
//   row_i, col_i  : Bayer matrix coordinates for this pixel
//   pix_i / pix_o : InW-bit input sample / registered OutW-bit result
module dither_channel
  import dithering_pkg::*;
#(
  parameter int unsigned InW       = 8,
  parameter int unsigned OutW      = 4,
  parameter int unsigned Threshold = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            clr_err_i,
  input  logic            line_end_i,
  input  mode_e           mode_i,
  input  logic [1:0]      row_i,
  input  logic [1:0]      col_i,
  input  logic [InW-1:0]  pix_i,
  output logic [OutW-1:0] pix_o
);

  localparam int unsigned L    = InW - OutW;
  localparam int unsigned SumW = InW + 2;

  logic signed [L:0]      err_q, err_d, err_cur, ed_err;
  logic signed [SumW-1:0] sum;
  logic [OutW-1:0]        pix_q, pix_d, quo, ed_pix, ord_pix, trunc_pix, sel_pix;
  logic [L-1:0]           rem, dither;
  logic [3:0]             bayer;
  logic [InW:0]           ord_sum;

  always_comb begin
    // Error diffusion
    err_cur = clr_err_i ? '0 : err_q;
    sum     = $signed({2'b00, pix_i}) + $signed({{(SumW - L - 1){err_cur[L]}}, err_cur});
    quo     = sum[InW-1:L];
    rem     = sum[L-1:0];
    if (sum[SumW-1]) begin
      ed_pix = '0;
      ed_err = '0;
    end else if (sum[InW]) begin
      ed_pix = '1;
      ed_err = '0;
    end else if (rem >= L'(Threshold) && quo != '1) begin
      ed_pix = quo + 1'b1;
      // rem - 2^L in L+1-bit two's complement is just a leading 1 above rem
      ed_err = {1'b1, rem};
    end else begin
      ed_pix = quo;
      ed_err = {1'b0, rem};
    end

    // Ordered dither: scale the 4-bit matrix value onto the L discarded bits
    bayer   = bayer_idx(row_i, col_i);
    dither  = L'((32'(bayer) << L) >> 4);
    ord_sum = {1'b0, pix_i} + (InW + 1)'(dither);
    ord_pix = ord_sum[InW] ? '1 : OutW'(ord_sum >> L);

    trunc_pix = pix_i[InW-1:L];

    case (mode_i)
      MODE_ED:  sel_pix = ed_pix;
      MODE_ORD: sel_pix = ord_pix;
      default:  sel_pix = trunc_pix;
    endcase

    // Error tracks every mode so a mode switch at the next frame starts cleanly
    pix_d = pix_q;
    err_d = err_q;
    if (valid_i) begin
      pix_d = sel_pix;
      err_d = line_end_i ? '0 : ed_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pix_q <= '0;
      err_q <= '0;
    end else begin
      pix_q <= pix_d;
      err_q <= err_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/dithering_rgb.sv
// Multi-channel pixel quantiser, IN_W -> OUT_W bits per channel, 1-cycle latency, no
// backpressure. Mode is latched on each valid frame-start pixel. Pixel x/y counters
// (kept mod 4, all the Bayer lookup needs) are shared by every channel.
// Optional: define DITHER_TEMPORAL_EN to rotate the Bayer pattern with a 2-bit frame counter.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   in_valid_i           : pixel qualifier
//   in_pixel_i           : CHANNELS*IN_W packed pixel
//   frame_start_i        : first pixel of frame (qualified by in_valid_i)
//   line_end_i           : last pixel of line (qualified by in_valid_i)
//   mode_i               : 00 truncate, 01 error diffusion, 10 ordered, 11 truncate
//   out_valid_o          : registered in_valid_i
//   out_pixel_o          : CHANNELS*OUT_W quantised pixel (holds when not valid)
//   out_frame_start_o    : qualified frame start, delayed 1 cycle
//   out_line_end_o       : qualified line end, delayed 1 cycle
module dithering_rgb
  import dithering_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 4,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  input  logic [CHANNELS*IN_W-1:0]  in_pixel_i,
  input  logic                      frame_start_i,
  input  logic                      line_end_i,
  input  logic [1:0]                mode_i,
  output logic                      out_valid_o,
  output logic [CHANNELS*OUT_W-1:0] out_pixel_o,
  output logic                      out_frame_start_o,
  output logic                      out_line_end_o
);

  logic       fs, le;
  mode_e      mode_dec, mode_cur, mode_q, mode_d;
  logic [1:0] x_q, x_d, y_q, y_d, x_cur, y_cur, col, row;
  logic       valid_q, fs_q, le_q;

  assign fs = in_valid_i & frame_start_i;
  assign le = in_valid_i & line_end_i;

  always_comb begin
    case (mode_i)
      2'b01:   mode_dec = MODE_ED;
      2'b10:   mode_dec = MODE_ORD;
      default: mode_dec = MODE_TRUNC;
    endcase
  end

  // The frame-start pixel already uses the new mode and origin coordinates
  assign mode_cur = fs ? mode_dec : mode_q;
  assign x_cur    = fs ? 2'd0 : x_q;
  assign y_cur    = fs ? 2'd0 : y_q;

`ifdef DITHER_TEMPORAL_EN
  logic [1:0] fc_q, fc_d;

  // Frame N after reset uses fc = N-1; the counter advances after the frame-start pixel
  assign col  = x_cur + {fc_q[0], 1'b0};
  assign row  = y_cur + {fc_q[1], 1'b0};
  assign fc_d = fs ? fc_q + 2'd1 : fc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) fc_q <= '0;
    else         fc_q <= fc_d;
  end
`else
  assign col = x_cur;
  assign row = y_cur;
`endif

  always_comb begin
    mode_d = mode_q;
    x_d    = x_q;
    y_d    = y_q;
    if (in_valid_i) begin
      mode_d = mode_cur;
      if (le) begin
        x_d = 2'd0;
        y_d = y_cur + 2'd1;
      end else begin
        x_d = x_cur + 2'd1;
        y_d = y_cur;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q  <= MODE_TRUNC;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= in_valid_i;
      fs_q    <= fs;
      le_q    <= le;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    dither_channel #(
      .InW       (IN_W),
      .OutW      (OUT_W),
      .Threshold (THRESHOLD)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .valid_i    (in_valid_i),
      .clr_err_i  (fs),
      .line_end_i (le),
      .mode_i     (mode_cur),
      .row_i      (row),
      .col_i      (col),
      .pix_i      (in_pixel_i[g*IN_W +: IN_W]),
      .pix_o      (out_pixel_o[g*OUT_W +: OUT_W])
    );
  end

  assign out_valid_o       = valid_q;
  assign out_frame_start_o = fs_q;
  assign out_line_end_o    = le_q;

endmodule

// File: tb/tb_dithering_rgb.sv
// Self-checking bench for dithering_rgb: an arithmetic reference model updated on every
// clock, a negedge compare process, and hand-computed literals on the top channel.
module tb_dithering_rgb;

  localparam int IW = 8;
  localparam int OW = 4;
  localparam int CH = 3;
  localparam int TH = 8;
  localparam int L  = IW - OW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [CH*IW-1:0]  in_pixel;
  logic              fs;
  logic              le;
  logic [1:0]        mode;
  logic              out_valid;
  logic [CH*OW-1:0]  out_pixel;
  logic              out_fs;
  logic              out_le;

  always #5 clk = ~clk;

  dithering_rgb #(
    .IN_W      (IW),
    .OUT_W     (OW),
    .CHANNELS  (CH),
    .THRESHOLD (TH)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .in_valid_i        (in_valid),
    .in_pixel_i        (in_pixel),
    .frame_start_i     (fs),
    .line_end_i        (le),
    .mode_i            (mode),
    .out_valid_o       (out_valid),
    .out_pixel_o       (out_pixel),
    .out_frame_start_o (out_fs),
    .out_line_end_o    (out_le)
  );

  int total = 0;
  int bad   = 0;

  int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // Reference model state
  int              m_err [CH];
  int              m_x, m_y, m_fc, m_mode;
  logic            exp_valid, exp_fs, exp_le;
  logic [CH*OW-1:0] exp_pix;
  int              lit_pend = -1;
  int              lit_cur  = -1;
  bit              chk_en   = 0;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int v, e, s, q, r, o, ne, col, row, d, maxo;
    maxo = (1 << OW) - 1;
    if (!rst_n) begin
      exp_valid = 0; exp_fs = 0; exp_le = 0; exp_pix = '0;
      for (int c = 0; c < CH; c++) m_err[c] = 0;
      m_x = 0; m_y = 0; m_fc = 0; m_mode = 0;
    end else begin
      exp_valid = in_valid;
      exp_fs    = in_valid && fs;
      exp_le    = in_valid && le;
      if (in_valid) begin
        if (fs) begin
          m_mode = mode;
          m_x = 0;
          m_y = 0;
        end
        for (int c = 0; c < CH; c++) begin
          v = int'(in_pixel[c*IW +: IW]);
          e = fs ? 0 : m_err[c];
          s = v + e;
          if (s < 0) begin
            ne = 0; q = 0;
          end else if (s > (1 << IW) - 1) begin
            ne = 0; q = maxo;
          end else begin
            q = s / (1 << L);
            r = s % (1 << L);
            if (r >= TH && q < maxo) begin
              q = q + 1; ne = r - (1 << L);
            end else begin
              ne = r;
            end
          end
          if (m_mode == 1) begin
            o = q;
          end else if (m_mode == 2) begin
            col = (m_x + 2 * (m_fc % 2)) % 4;
            row = (m_y + 2 * (m_fc / 2)) % 4;
            d   = (bay[row][col] * (1 << L)) / 16;
            s   = v + d;
            if (s > (1 << IW) - 1) s = (1 << IW) - 1;
            o   = s / (1 << L);
          end else begin
            o = v / (1 << L);
          end
          exp_pix[c*OW +: OW] = o[OW-1:0];
          m_err[c] = le ? 0 : ne;
        end
        if (le) begin
          m_x = 0; m_y = m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
`ifdef DITHER_TEMPORAL_EN
        if (fs) m_fc = (m_fc + 1) % 4;
`endif
      end
    end
    lit_cur = lit_pend;
    chk_en  = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("out_pixel", int'(out_pixel), int'(exp_pix));
      chk("out_frame_start", int'(out_fs), int'(exp_fs));
      chk("out_line_end", int'(out_le), int'(exp_le));
      if (lit_cur >= 0) chk("literal_top_channel", int'(out_pixel[CH*OW-1 -: OW]), lit_cur);
    end
  end

  task automatic rst_cycle();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    in_pixel = CH*IW'($urandom);
    fs       = 1'($urandom);
    le       = 1'($urandom);
    mode     = 2'($urandom);
    lit_pend = 0;
  endtask

  // One valid pixel on the top channel, other channels 0; lit < 0 means no literal check
  task automatic px(input logic [7:0] v, input bit f, input bit l, input logic [1:0] md,
                    input int lit);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_pixel = {v, {(CH - 1) * IW{1'b0}}};
    fs       = f;
    le       = l;
    mode     = md;
    lit_pend = lit;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_pixel = CH*IW'($urandom);
    fs       = 1'($urandom);
    le       = 1'($urandom);
    mode     = 2'($urandom);
    lit_pend = -1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    in_pixel = CH*IW'($urandom);
    fs       = 1'($urandom);
    le       = 1'($urandom);
    mode     = 2'($urandom);
    repeat (3) rst_cycle();

    // First pixel after reset in ED mode: error starts at 0
    px(8'h08, 1, 0, 2'b01, 1);
    px(8'h08, 0, 0, 2'b01, 0);

    // Truncate, mid-frame mode change ignored
    px(8'h7F, 1, 0, 2'b00, 7);
    px(8'h7F, 0, 0, 2'b01, 7);
    px(8'h08, 0, 1, 2'b10, 0);

    // Error diffusion alternating pattern, held across an idle cycle
    px(8'h08, 1, 0, 2'b01, 1);
    px(8'h08, 0, 0, 2'b00, 0);
    px(8'h08, 0, 0, 2'b00, 1);
    px(8'h08, 0, 0, 2'b00, 0);
    idle();
    px(8'h08, 0, 0, 2'b00, 1);
    // Saturation high
    px(8'hFF, 1, 0, 2'b01, 15);
    px(8'hFF, 0, 0, 2'b01, 15);
    px(8'hFF, 0, 0, 2'b01, 15);
    // Negative sum clamps to 0
    px(8'h08, 1, 0, 2'b01, 1);
    px(8'h03, 0, 0, 2'b01, 0);
    px(8'h08, 0, 0, 2'b01, 1);

    // Line end clears error
    px(8'h08, 1, 0, 2'b01, 1);
    px(8'h08, 0, 0, 2'b01, 0);
    px(8'h08, 0, 1, 2'b01, 1);
    px(8'h08, 0, 0, 2'b01, 1);
    // Frame start and line end on the same pixel
    px(8'h08, 1, 1, 2'b01, 1);
    px(8'h08, 0, 0, 2'b01, 1);

    // Ordered: row 0, row 1, then flat black and white rows
    px(8'h08, 1, 0, 2'b10, 0);
    px(8'h08, 0, 0, 2'b00, 1);
    px(8'h08, 0, 0, 2'b00, 0);
    px(8'h08, 0, 1, 2'b00, 1);
    px(8'h08, 0, 0, 2'b00, 1);
    idle();
    px(8'h08, 0, 0, 2'b00, 0);
    px(8'h08, 0, 0, 2'b00, 1);
    px(8'h08, 0, 1, 2'b00, 0);
    for (int i = 0; i < 4; i++) px(8'h00, 0, i == 3, 2'b00, 0);
    for (int i = 0; i < 4; i++) px(8'hFF, 0, i == 3, 2'b00, 15);
    px(8'hF7, 0, 0, 2'b00, 15);
    px(8'h17, 0, 0, 2'b00, -1);

    // Several more ordered frames (row 0 pattern of 8'h08 is 0,1,0,1 for any rotation)
    for (int f = 0; f < 4; f++) begin
      px(8'h08, 1, 0, 2'b10, 0);
      px(8'h08, 0, 0, 2'b10, 1);
      px(8'h08, 0, 0, 2'b10, 0);
      px(8'h08, 0, 1, 2'b10, 1);
      px(8'h08, 0, 0, 2'b10, -1);
      px(8'h3C, 0, 0, 2'b10, -1);
      px(8'h9A, 0, 1, 2'b10, -1);
    end

    // Mode 11 behaves as truncate
    px(8'h7F, 1, 0, 2'b11, 7);
    px(8'hA5, 0, 1, 2'b01, 10);

    // Mixed channels through the model
    @(posedge clk); #1;
    in_valid = 1'b1; fs = 1'b1; le = 1'b0; mode = 2'b01; in_pixel = 24'h18_2C_F3;
    lit_pend = -1;
    @(posedge clk); #1;
    fs = 1'b0; in_pixel = 24'h07_81_0E;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
